// File: rtl/emissor_pkg.sv
// rtl/emissor_pkg.sv - shared types and constants for the code emitter
// Contents: FSM state enum, lock display patterns {A..G} (A in bit 6),
// and the 2-bit outcome codes reported on resultado.
package emissor_pkg;

   typedef enum logic [2:0] {
      OCIOSO,
      PULSO,
      INTERVALO,
      ESPERA,
      PRONTO
   } estado_t;

   localparam logic [6:0] SEG_ABERTO      = 7'b1011011;
   localparam logic [6:0] SEG_ABERTO_ERRO = 7'b1100111;
   localparam logic [6:0] SEG_FALHA       = 7'b1000111;

   localparam logic [1:0] RES_INDEF   = 2'b00;
   localparam logic [1:0] RES_OK      = 2'b01;
   localparam logic [1:0] RES_OK_ERRO = 2'b10;
   localparam logic [1:0] RES_FALHA   = 2'b11;

endpackage

// File: rtl/classificador_segmentos.sv
// rtl/classificador_segmentos.sv - maps the lock display to an outcome code
// Ports:
//   segs        in  7  lock display {A,B,C,D,E,F,G}, A in bit 6
//   codigo_res  out 2  outcome code (RES_INDEF unless an exact pattern match)
module classificador_segmentos
   import emissor_pkg::*;
(
   input  logic [6:0] segs,
   output logic [1:0] codigo_res
);

   always_comb begin
      codigo_res = RES_INDEF;
      case (segs)
         SEG_ABERTO:      codigo_res = RES_OK;
         SEG_ABERTO_ERRO: codigo_res = RES_OK_ERRO;
         SEG_FALHA:       codigo_res = RES_FALHA;
         default:         codigo_res = RES_INDEF;
      endcase
   end

endmodule

// File: rtl/emissor_codigo.sv
// rtl/emissor_codigo.sv - replays a BCD digit sequence into the lock and reads its verdict
// Ports:
//   clk        in  1                rising-edge clock
//   reset      in  1                asynchronous active-high reset
//   start      in  1                send request, honoured only while idle
//   codigo     in  4*NUM_DIGITS     digit k in [4k+3:4k], digit 0 sent first
//   segs       in  7                lock display {A..G}, A in bit 6
//   numero     out 4 ([4:1])        digit presented to the lock
//   insere     out 1                one-cycle strobe per digit
//   ocupado    out 1                busy, from the cycle after acceptance through PRONTO
//   pronto     out 1                one-cycle pulse when resultado becomes valid
//   resultado  out 2                outcome code, held until next accepted start
module emissor_codigo
   import emissor_pkg::*;
#(
   parameter int NUM_DIGITS    = 6,
   parameter int GAP_CYCLES    = 1,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [4*NUM_DIGITS-1:0] codigo,
   input  logic [6:0]              segs,
   output logic [4:1]              numero,
   output logic                    insere,
   output logic                    ocupado,
   output logic                    pronto,
   output logic [1:0]              resultado
);

   localparam int SR_W  = 4 * NUM_DIGITS;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(NUM_DIGITS - 1);
   localparam logic [GAP_W-1:0] GAP_FIM    = GAP_W'(GAP_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_FIM    = SET_W'(SETTLE_CYCLES - 1);

   estado_t           estado, estado_prox;
   logic [SR_W-1:0]   sr, sr_prox, sr_desloc;
   logic [IDX_W-1:0]  idx, idx_prox;
   logic [GAP_W-1:0]  gap_cnt, gap_prox;
   logic [SET_W-1:0]  set_cnt, set_prox;
   logic [4:1]        numero_prox;
   logic              insere_prox, ocupado_prox, pronto_prox;
   logic [1:0]        resultado_prox;
   logic [1:0]        classe;

   classificador_segmentos u_classificador (
      .segs       (segs),
      .codigo_res (classe)
   );

   // The current digit always sits in sr[3:0]; shifting exposes the next one.
   assign sr_desloc = sr >> 4;

   // Outputs are computed for the state being entered and registered, so
   // insere/numero/pronto are glitch-free and aligned with the state.
   always_comb begin
      estado_prox    = estado;
      sr_prox        = sr;
      idx_prox       = idx;
      gap_prox       = gap_cnt;
      set_prox       = set_cnt;
      numero_prox    = numero;
      insere_prox    = 1'b0;
      ocupado_prox   = ocupado;
      pronto_prox    = 1'b0;
      resultado_prox = resultado;

      case (estado)
         OCIOSO: begin
            if (start) begin
               sr_prox        = codigo;
               idx_prox       = '0;
               resultado_prox = RES_INDEF;
               numero_prox    = codigo[3:0];
               insere_prox    = 1'b1;
               ocupado_prox   = 1'b1;
               estado_prox    = PULSO;
            end
         end
         PULSO: begin
            gap_prox    = '0;
            estado_prox = INTERVALO;
         end
         INTERVALO: begin
            if (gap_cnt == GAP_FIM) begin
               gap_prox = '0;
               if (idx == IDX_ULTIMO) begin
                  set_prox    = '0;
                  estado_prox = ESPERA;
               end else begin
                  idx_prox    = idx + IDX_W'(1);
                  sr_prox     = sr_desloc;
                  numero_prox = sr_desloc[3:0];
                  insere_prox = 1'b1;
                  estado_prox = PULSO;
               end
            end else begin
               gap_prox = gap_cnt + GAP_W'(1);
            end
         end
         ESPERA: begin
            // The lock display is sampled on the edge that leaves ESPERA.
            if (set_cnt == SET_FIM) begin
               set_prox       = '0;
               resultado_prox = classe;
               pronto_prox    = 1'b1;
               estado_prox    = PRONTO;
            end else begin
               set_prox = set_cnt + SET_W'(1);
            end
         end
         PRONTO: begin
            ocupado_prox = 1'b0;
            estado_prox  = OCIOSO;
         end
         default: begin
            ocupado_prox = 1'b0;
            estado_prox  = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado    <= OCIOSO;
         sr        <= '0;
         idx       <= '0;
         gap_cnt   <= '0;
         set_cnt   <= '0;
         numero    <= '0;
         insere    <= 1'b0;
         ocupado   <= 1'b0;
         pronto    <= 1'b0;
         resultado <= RES_INDEF;
      end else begin
         estado    <= estado_prox;
         sr        <= sr_prox;
         idx       <= idx_prox;
         gap_cnt   <= gap_prox;
         set_cnt   <= set_prox;
         numero    <= numero_prox;
         insere    <= insere_prox;
         ocupado   <= ocupado_prox;
         pronto    <= pronto_prox;
         resultado <= resultado_prox;
      end
   end

endmodule

// File: doc/emissor_codigo.md
Name: emissor_codigo

Overview:
Drives the combination-lock entry interface from the transmitting side. It replays a stored sequence of NUM_DIGITS BCD digits as single-cycle `insere` strobes with `numero` held stable. After the last digit it waits a settle time, then samples the lock's seven-segment outputs and classifies the outcome. It sits in front of the lock on the board/bench: it acts as the automated keypad and reads back the lock's verdict.

Parameters:
- NUM_DIGITS, 6: digits per sequence; minimum 1.
- GAP_CYCLES, 1: idle cycles after each `insere` pulse with `numero` held; minimum 1.
- SETTLE_CYCLES, 3: cycles waited after the last gap before sampling `segs`; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to send `codigo`; sampled only in OCIOSO.
- codigo  in  4*NUM_DIGITS  digit k in bits [4k+3:4k]; digit 0 is sent first; latched on accepted start.
- segs  in  7  lock display, {A,B,C,D,E,F,G}, A in bit 6.
- numero  out  4 ([4:1])  digit presented to the lock.
- insere  out  1  one-cycle strobe per digit.
- ocupado  out  1  high from the cycle after start is accepted through the PRONTO cycle.
- pronto  out  1  one-cycle pulse when `resultado` becomes valid.
- resultado  out  2  outcome: 00 = indeterminate, 01 = open with no error, 10 = open with error used, 11 = fail.

Behaviour:
- Reset values (asynchronous, immediate): numero=0000, insere=0, ocupado=0, pronto=0, resultado=00, state OCIOSO, counters 0. Reset mid-operation aborts at once; no further strobes are issued.
- Registered outputs only. `insere` never glitches. `numero` changes only in cycles where `insere`=0, or in the same cycle as the next rising `insere`.
- States:
  - OCIOSO: if start=1, latch codigo into a shift register, set idx=0, clear resultado to 00, go to PULSO.
  - PULSO (1 cycle): insere=1, numero=digit[idx]; go to INTERVALO.
  - INTERVALO (GAP_CYCLES cycles): insere=0, numero held. At the end, if idx=NUM_DIGITS-1 go to ESPERA; else idx+1, shift, go to PULSO.
  - ESPERA (SETTLE_CYCLES cycles): outputs static.
  - PRONTO (1 cycle): pronto=1, resultado holds the classification of `segs` sampled at the final ESPERA edge; then go to OCIOSO.
- Timing: start sampled at edge 0. The digit k pulse occurs in cycle 1+k*(1+GAP_CYCLES). pronto occurs in cycle 1+NUM_DIGITS*(1+GAP_CYCLES)+SETTLE_CYCLES. For the defaults: pulses in cycles 1,3,5,7,9,11 and pronto in cycle 16.
- Classification is an exact 7-bit match on {A..G}:
  - 1011011 → 01
  - 1100111 → 10
  - 1000111 → 11
  - anything else (for example a plain digit pattern) → 00
- `resultado` holds its value until the next accepted start or reset.
- start while ocupado=1 is ignored, with no queueing. start held high re-triggers in the cycle after PRONTO returns to OCIOSO.
- Digit values 1010–1111 are sent unmodified; no checking is done.
- idx width is clog2(NUM_DIGITS). Gap and settle counters are sized to their parameters and are not free-running.

Decomposition:
- Shared package emissor_pkg:
  - state enum (OCIOSO, PULSO, INTERVALO, ESPERA, PRONTO)
  - segment constants SEG_ABERTO=7'b1011011, SEG_ABERTO_ERRO=7'b1100111, SEG_FALHA=7'b1000111
  - resultado codes RES_INDEF / RES_OK / RES_OK_ERRO / RES_FALHA
- One natural sub-module: classificador_segmentos, purely combinational, mapping segs[6:0] to a 2-bit result code. The FSM, counters and shift register stay in emissor_codigo.

Test Plan:
1. Assert reset, then release with no start → all outputs at reset values. Assert reset again in cycle 6 of an active send → insere=0 and ocupado=0 immediately, with no further pulses.
2. codigo digits 5,9,0,9,8,1, defaults, lock model attached → insere high in cycles 1,3,5,7,9,11 with numero=5,9,0,9,8,1; pronto in cycle 16; resultado=01.
3. NUM_DIGITS=7, digits 5,3,9,0,9,8,1 → lock shows 1100111; resultado=10; pronto in cycle 1+7*2+3=18.
4. Digits 5,3,4,0,9,8 → lock shows 1000111 → resultado=11.
5. Digits 1,2,3,4,5,6 with segs forced to a digit pattern 0110000 → resultado=00. A start pulse in cycle 4 is ignored: pulse count stays 6 and ocupado is unchanged.
6. GAP_CYCLES=3, SETTLE_CYCLES=2, start held high continuously → pulses every 4 cycles. After pronto, the next sequence's first pulse follows within 2 cycles, and resultado is cleared to 00 on re-acceptance.
